// File: rtl/bram_bist_pkg.sv
// Shared definitions for the block-RAM self-test initiator.
// Contents: the FSM state encoding and the test-pattern function P(a, seed, pass).
// The pattern is computed at 32 bits; callers size-cast it to their word width.
package bram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int PAT_W = 32;

  // Pass 0 stores addr ^ seed and pass 1 stores its complement, so every cell
  // is exercised at both polarities. The caller zero-extends addr and seed to
  // PAT_W and truncates the result, which gives a[DW-1:0] ^ SEED.
  function automatic logic [PAT_W-1:0] bist_pattern(input logic [PAT_W-1:0] addr,
                                                    input logic [PAT_W-1:0] seed,
                                                    input logic             pass);
    logic [PAT_W-1:0] p;
    p = addr ^ seed;
    return pass ? ~p : p;
  endfunction

endpackage

// File: rtl/bram_bist_checker.sv
// Read-back checker. It delays the expected word, address and valid to line up with RAM read data.
// Ports: i_cmp_vld/i_exp_dat/i_cmp_addr describe a read issued this cycle; i_mem_dout is RAM data;
//        o_fail/o_fail_addr/o_err_count hold the sticky result; i_clear zeroes the result.
module bram_bist_checker
  import bram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int SYNC_READ  = 1,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_cmp_vld,
  input  logic [DATA_WIDTH-1:0] i_exp_dat,
  input  logic [ADDR_WIDTH-1:0] i_cmp_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic                  o_fail,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [ERR_WIDTH-1:0]  o_err_count
);

  logic                  w_vld;
  logic [DATA_WIDTH-1:0] w_exp;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_mismatch;

  logic                  r_fail;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [ERR_WIDTH-1:0]  r_err_count;

  // A registered-DOUT RAM returns data one cycle after the address is
  // presented, so the expected word and address travel through one stage.
  generate
    if (SYNC_READ != 0) begin : g_dly
      logic                  r_vld;
      logic [DATA_WIDTH-1:0] r_exp;
      logic [ADDR_WIDTH-1:0] r_addr;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_vld  <= 1'b0;
          r_exp  <= '0;
          r_addr <= '0;
        end else begin
          r_vld  <= i_cmp_vld;
          r_exp  <= i_exp_dat;
          r_addr <= i_cmp_addr;
        end
      end

      assign w_vld  = r_vld;
      assign w_exp  = r_exp;
      assign w_addr = r_addr;
    end else begin : g_nodly
      assign w_vld  = i_cmp_vld;
      assign w_exp  = i_exp_dat;
      assign w_addr = i_cmp_addr;
    end
  endgenerate

  assign w_mismatch = w_vld && (i_mem_dout != w_exp);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_err_count <= '0;
    end else if (w_mismatch) begin
      if (r_err_count != '1) begin
        r_err_count <= r_err_count + ERR_WIDTH'(1);
      end
      // Only the first failing address is kept; later ones just count.
      if (!r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= w_addr;
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/bram_bist.sv
// Built-in self-test for one block RAM. It runs two write/read-back passes (pattern, then complement).
// Ports: i_start launches a test; o_mem_* drive the RAM and i_mem_dout is read back;
//        o_busy/o_done give status and o_fail/o_fail_addr/o_err_count give the result.
module bram_bist
  import bram_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    ADDR_WIDTH = 14,
  parameter int                    SYNC_READ  = 1,
  parameter logic [DATA_WIDTH-1:0] SEED       = 4'h5,
  parameter int                    ERR_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_din,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [ERR_WIDTH-1:0]  o_err_count
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  r_pass;
  logic                  w_pass_nxt;
  logic                  w_start_ok;
  logic                  w_last;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic [DATA_WIDTH-1:0] w_din_nxt;
  logic [DATA_WIDTH-1:0] w_exp_cur;

  assign w_last = (r_addr == '1);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pass_nxt  = r_pass;
    w_start_ok  = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_WR;
          w_addr_nxt  = '0;
          w_pass_nxt  = 1'b0;
          w_start_ok  = 1'b1;
        end
      end
      ST_WR: begin
        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
        if (w_last) begin
          w_state_nxt = ST_RD;
          w_addr_nxt  = '0;
        end
      end
      ST_RD: begin
        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
        if (w_last) begin
          w_addr_nxt = '0;
          // A combinational-read RAM has no outstanding data, so it skips DRAIN.
          if (SYNC_READ != 0) begin
            w_state_nxt = ST_DRAIN;
          end else if (!r_pass) begin
            w_state_nxt = ST_WR;
            w_pass_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (!r_pass) begin
          w_state_nxt = ST_WR;
          w_pass_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // RAM-side outputs are computed from the next state, so they are registered
  // and line up with the state they belong to.
  assign w_din_nxt = (w_state_nxt == ST_WR) ?
                     DATA_WIDTH'(bist_pattern(32'(w_addr_nxt), 32'(SEED), w_pass_nxt)) : '0;
  assign w_exp_cur = DATA_WIDTH'(bist_pattern(32'(r_addr), 32'(SEED), r_pass));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_pass    <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_din <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_pass    <= w_pass_nxt;
      r_mem_we  <= (w_state_nxt == ST_WR);
      r_mem_din <= w_din_nxt;
    end
  end

  bram_bist_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SYNC_READ  (SYNC_READ),
    .ERR_WIDTH  (ERR_WIDTH)
  ) u_checker (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_start_ok),
    .i_cmp_vld   (r_state == ST_RD),
    .i_exp_dat   (w_exp_cur),
    .i_cmp_addr  (r_addr),
    .i_mem_dout  (i_mem_dout),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_err_count (o_err_count)
  );

  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_addr;
  assign o_mem_din  = r_mem_din;
  assign o_busy     = (r_state == ST_WR) || (r_state == ST_RD) || (r_state == ST_DRAIN);
  assign o_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_bram_bist.sv
// Testbench for bram_bist: three instances (registered read, combinational read, 3-bit error counter)
// Each instance is attached to a behavioural 16x4 RAM with injectable read faults.
// Expected results come from a pass/address-level reference model.
module tb_bram_bist;

  localparam int SEED_I = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i [3];
  logic       we_o    [3];
  logic [3:0] addr_o  [3];
  logic [3:0] din_o   [3];
  logic [3:0] dout_i  [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       fail_o  [3];
  logic [3:0] faddr_o [3];
  logic [7:0] err_o   [3];
  logic [7:0] err0, err1;
  logic [2:0] err2;

  logic [3:0] mem [3][16];
  logic [3:0] rq0, rq2;
  int fmode, fa, fb, fv;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .SYNC_READ(1), .SEED(4'h5), .ERR_WIDTH(8)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start_i[0]), .o_mem_we(we_o[0]), .o_mem_addr(addr_o[0]),
    .o_mem_din(din_o[0]), .i_mem_dout(dout_i[0]), .o_busy(busy_o[0]), .o_done(done_o[0]),
    .o_fail(fail_o[0]), .o_fail_addr(faddr_o[0]), .o_err_count(err0));

  bram_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .SYNC_READ(0), .SEED(4'h5), .ERR_WIDTH(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start_i[1]), .o_mem_we(we_o[1]), .o_mem_addr(addr_o[1]),
    .o_mem_din(din_o[1]), .i_mem_dout(dout_i[1]), .o_busy(busy_o[1]), .o_done(done_o[1]),
    .o_fail(fail_o[1]), .o_fail_addr(faddr_o[1]), .o_err_count(err1));

  bram_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .SYNC_READ(1), .SEED(4'h5), .ERR_WIDTH(3)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start_i[2]), .o_mem_we(we_o[2]), .o_mem_addr(addr_o[2]),
    .o_mem_din(din_o[2]), .i_mem_dout(dout_i[2]), .o_busy(busy_o[2]), .o_done(done_o[2]),
    .o_fail(fail_o[2]), .o_fail_addr(faddr_o[2]), .o_err_count(err2));

  assign err_o[0] = err0;
  assign err_o[1] = err1;
  assign err_o[2] = {5'b0, err2};

  // RAM read path with an optional fault: mode 1 = one bit stuck at one address, mode 2 = reads all zero.
  function automatic logic [3:0] rd_fault(input logic [3:0] v, input int a, input int mode,
                                          input int f_a, input int f_b, input int f_v);
    logic [3:0] r;
    r = v;
    if (mode == 2) r = 4'h0;
    else if (mode == 1 && a == f_a) r[f_b] = f_v[0];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) if (we_o[k]) mem[k][addr_o[k]] <= din_o[k];
    rq0 <= rd_fault(mem[0][addr_o[0]], int'(addr_o[0]), fmode, fa, fb, fv);
    rq2 <= rd_fault(mem[2][addr_o[2]], int'(addr_o[2]), fmode, fa, fb, fv);
  end
  assign dout_i[0] = rq0;
  assign dout_i[1] = rd_fault(mem[1][addr_o[1]], int'(addr_o[1]), fmode, fa, fb, fv);
  assign dout_i[2] = rq2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-test outcome: walk both passes over every address, in order.
  function automatic void ref_model(input int maxe, output int err, output int faddr, output int fail);
    int w, r;
    err = 0; faddr = 0; fail = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 16; a++) begin
        w = ((a ^ SEED_I) ^ (p == 1 ? 15 : 0)) & 15;
        r = int'(rd_fault(4'(w), a, fmode, fa, fb, fv));
        if (r != w) begin
          if (fail == 0) begin fail = 1; faddr = a; end
          if (err < maxe) err++;
        end
      end
    end
  endfunction

  task automatic run_test(input int k, input int hold, input string tag);
    int cnt, guard, nw, bad, e_err, e_fa, e_fail, e_busy, ea, ed;
    ref_model((k == 2) ? 7 : 255, e_err, e_fa, e_fail);
    e_busy = (k == 1) ? 64 : 66;
    start_i[k] = 1'b1;
    @(negedge clk);
    if (hold == 0) start_i[k] = 1'b0;
    chk({tag, "_first_busy"}, 32'(busy_o[k]), 1);
    chk({tag, "_first_we"}, 32'(we_o[k]), 1);
    chk({tag, "_first_addr"}, 32'(addr_o[k]), 0);
    chk({tag, "_first_din"}, 32'(din_o[k]), SEED_I);
    chk({tag, "_clr_fail"}, 32'(fail_o[k]), 0);
    chk({tag, "_clr_err"}, 32'(err_o[k]), 0);
    cnt = 0; guard = 0; nw = 0; bad = 0;
    while (busy_o[k] && guard < 300) begin
      if (we_o[k]) begin
        ea = nw % 16;
        ed = ((ea ^ SEED_I) ^ ((nw >= 16) ? 15 : 0)) & 15;
        if (int'(addr_o[k]) != ea || int'(din_o[k]) != ed) bad++;
        nw++;
      end
      cnt++;
      @(negedge clk);
      guard++;
    end
    start_i[k] = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'(e_busy));
    chk({tag, "_wr_count"}, 32'(nw), 32);
    chk({tag, "_wr_seq_bad"}, 32'(bad), 0);
    chk({tag, "_done"}, 32'(done_o[k]), 1);
    chk({tag, "_fail"}, 32'(fail_o[k]), 32'(e_fail));
    chk({tag, "_fail_addr"}, 32'(faddr_o[k]), 32'(e_fa));
    chk({tag, "_err_count"}, 32'(err_o[k]), 32'(e_err));
  endtask

  task automatic set_fault(input int m, input int a, input int b, input int v);
    fmode = m; fa = a; fb = b; fv = v;
  endtask

  initial begin
    int k, gap;
    for (int i = 0; i < 3; i++) start_i[i] = 1'b0;
    set_fault(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", 32'(we_o[0]), 0);
    chk("rst_addr", 32'(addr_o[0]), 0);
    chk("rst_din", 32'(din_o[0]), 0);
    chk("rst_busy", 32'(busy_o[0]), 0);
    chk("rst_done", 32'(done_o[0]), 0);
    chk("rst_fail", 32'(fail_o[0]), 0);
    chk("rst_faddr", 32'(faddr_o[0]), 0);
    chk("rst_err", 32'(err_o[0]), 0);

    run_test(0, 0, "good_sync");
    run_test(1, 0, "good_comb");
    set_fault(1, 9, 2, 0);
    run_test(0, 0, "stuck_a9b2");
    // Fault removed and START held through the run: no restart, results cleared.
    set_fault(0, 0, 0, 0);
    run_test(0, 1, "hold_start");
    set_fault(2, 0, 0, 0);
    run_test(2, 0, "zero_sat");
    set_fault(0, 0, 0, 0);

    // Reset in cycle 20 of a test.
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    for (int i = 1; i < 20; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", 32'(we_o[0]), 0);
    chk("midrst_busy", 32'(busy_o[0]), 0);
    chk("midrst_done", 32'(done_o[0]), 0);
    chk("midrst_addr", 32'(addr_o[0]), 0);
    chk("midrst_din", 32'(din_o[0]), 0);
    chk("midrst_err", 32'(err_o[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    run_test(0, 0, "after_rst");

    for (int it = 0; it < 8; it++) begin
      k = int'($urandom_range(0, 2));
      set_fault(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 4));
      repeat (gap) @(negedge clk);
      run_test(k, int'($urandom_range(0, 1)), $sformatf("rnd%0d_k%0d_m%0d", it, k, fmode));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_bist.md
# bram_bist

Built-in self-test initiator for a single block RAM of the `ram` type (synchronous write, optional synchronous read). It drives the RAM's write-enable, address and write-data pins, reads every word back, compares against a deterministic pattern and reports pass/fail. It sits beside each BRAM instance in the pcbfpga example designs, so place-and-route results can be checked on silicon without an external tester.

## Interface
- `DATA_WIDTH`, 4, RAM word width; must match the attached RAM.
- `ADDR_WIDTH`, 14, RAM address width; depth is 2^ADDR_WIDTH.
- `SYNC_READ`, 1, RAM read latency: 1 means registered DOUT, 0 means combinational DOUT.
- `SEED`, 4'h5, pattern seed, truncated or zero-extended to DATA_WIDTH.
- `ERR_WIDTH`, 8, width of the saturating error counter.

Ports:
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `START` in 1: begin a test. Sampled only in IDLE or DONE.
- `MEM_WE` out 1: RAM write enable.
- `MEM_ADDR` out ADDR_WIDTH: RAM address. Drives both ADDR and ADDR2 of a dual-port RAM.
- `MEM_DIN` out DATA_WIDTH: RAM write data.
- `MEM_DOUT` in DATA_WIDTH: RAM read data.
- `BUSY` out 1: test in progress.
- `DONE` out 1: test finished. Held until START or RST.
- `FAIL` out 1: at least one mismatch. Valid while DONE=1.
- `FAIL_ADDR` out ADDR_WIDTH: address of the first mismatch.
- `ERR_COUNT` out ERR_WIDTH: number of mismatches, saturates at all-ones.

## Operation
- Pattern: P(a) = a[DATA_WIDTH-1:0] ^ SEED. If ADDR_WIDTH < DATA_WIDTH, the address is zero-extended first.
- The test runs two passes. Pass 0 writes and checks P(a). Pass 1 writes and checks ~P(a).
- The FSM has five states:
  - IDLE, leaves to WR when START=1.
  - WR: writes a = 0 up to 2^AW-1, one word per cycle, then goes to RD.
  - RD: issues reads a = 0 up to 2^AW-1, one per cycle. When SYNC_READ=1 it goes to DRAIN; when SYNC_READ=0 it leaves directly after the last read.
  - DRAIN lasts one cycle. After it the FSM goes to WR with pass 1 if the current pass is 0, otherwise to DONE.
  - DONE leaves to WR with pass 0 on START=1.
- The compare path has exactly SYNC_READ cycles of delay. It carries the expected word and the address alongside the read, and compares MEM_DOUT against the delayed expected word.
- On a mismatch, ERR_COUNT increments and saturates. FAIL_ADDR is captured only on the first mismatch, i.e. when FAIL=0 before that mismatch. FAIL is then set.
- START in DONE clears FAIL, FAIL_ADDR and ERR_COUNT on the same edge that enters WR.
- START is ignored while BUSY=1.
- The address counter wraps to 0 at each phase change; the counter is never reused across a wrap.

## Timing
- Reset values: MEM_WE=0, MEM_ADDR=0, MEM_DIN=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, ERR_COUNT=0. The state returns to IDLE with pass 0.
- RST mid-test takes effect on the next edge, and MEM_WE=0 from that cycle on. Partial RAM contents are left in place.
- START is sampled high at edge k. From cycle k+1: BUSY=1, MEM_WE=1, MEM_ADDR=0, MEM_DIN=P(0).
- All RAM-side outputs are registered.
- MEM_WE=0 in every cycle outside WR.
- Total busy cycles = 2·(2·2^AW + SYNC_READ).
- DONE rises in the cycle after the last compare. BUSY falls in that same cycle, and FAIL and ERR_COUNT are already final.
- Compare for read address a happens in the cycle when MEM_ADDR=a plus SYNC_READ cycles.

## Structure
- Package `bram_bist_pkg`: state enum (IDLE, WR, RD, DRAIN, DONE) and the pattern function P(a, seed, pass).
- Sub-module `bram_bist_checker`:
  - the SYNC_READ-deep expected/address/valid delay line;
  - the comparator;
  - the saturating ERR_COUNT;
  - first-fail capture into FAIL/FAIL_ADDR.
- The top level holds the FSM, the address counter and the pass bit.

## Test plan
All scenarios use ADDR_WIDTH=4, DATA_WIDTH=4, SEED=4'h5, and the bench attaches a behavioural `ram` model.
- Good RAM, SYNC_READ=1, START pulse → BUSY high for 66 cycles, then DONE=1, FAIL=0, ERR_COUNT=0. The first write cycle shows MEM_ADDR=0 and MEM_DIN=4'h5.
- Good RAM, SYNC_READ=0 → BUSY for 64 cycles, then DONE=1 and FAIL=0.
- RAM model with bit 2 of address 4'h9 stuck at 0 → FAIL=1, FAIL_ADDR=4'h9, ERR_COUNT=1. Pass 0 writes P(9)=4'hC, whose bit 2 is already 1, so pass 0 reads back 4'h8 and mismatches. Pass 1 writes 4'h3, bit 2 is 0, so it matches.
- Every read returns 4'h0, with ERR_WIDTH=3 → ERR_COUNT saturates at 7, FAIL_ADDR=0, DONE=1.
- RST asserted in cycle 20 of a test → MEM_WE=0 and BUSY=0 next cycle, every output at its reset value. A new START then runs a full 66-cycle test with FAIL=0.
- START held high during a test and again in DONE → the test is not restarted mid-run. START in DONE clears FAIL/ERR_COUNT and begins with MEM_ADDR=0 the next cycle.
